ex_wb_stage: RTL

- Execute stage plus EX/WB pipeline register for the 8-bit, 8-register pipelined core; sits directly downstream of the ID/EX register.
- Each cycle it takes the ID/EX-registered operand, immediate, register numbers and controls, and forwards the register operand from the two younger in-flight results.
- It evaluates a 2-bit ALU op and registers the result, destination register and RegWrite into EX/WB; those outputs drive the register-file write port.

---
 rtl/ex_wb_stage_if.sv | 46 ++++
 rtl/ex_wb_stage.sv | 113 +++++++++++
 2 files changed

// File: rtl/ex_wb_stage_if.sv
// ex_wb_stage_if: bus between the ID/EX pipeline register, the execute stage
// and the register-file write port.
//   master: drives the ID/EX fields and Flush, observes the EX/WB outputs.
//   slave : the execute stage (consumes ID/EX, produces EX/WB and Fwd_Sel).
// Optional macro EX_WB_FLAGS_EN adds EX_WB_Zero / EX_WB_Carry.
interface ex_wb_stage_if #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 3
);
  logic              ID_EX_RegWrite;
  logic              ID_EX_ALUSrc;
  logic [1:0]        ID_EX_ALUOp;
  logic [DATA_W-1:0] ID_EX_Read_Data;
  logic [DATA_W-1:0] ID_EX_Imm_Data;
  logic [REG_W-1:0]  ID_EX_Read_Reg_Num;
  logic [REG_W-1:0]  ID_EX_Write_Reg_Num;
  logic              Flush;
  logic              EX_WB_RegWrite;
  logic [DATA_W-1:0] EX_WB_Write_Data;
  logic [REG_W-1:0]  EX_WB_Write_Reg_Num;
  logic [1:0]        Fwd_Sel;
`ifdef EX_WB_FLAGS_EN
  logic              EX_WB_Zero;
  logic              EX_WB_Carry;
`endif

  modport master (
    output ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_Read_Data,
           ID_EX_Imm_Data, ID_EX_Read_Reg_Num, ID_EX_Write_Reg_Num, Flush,
    input
`ifdef EX_WB_FLAGS_EN
           EX_WB_Zero, EX_WB_Carry,
`endif
           EX_WB_RegWrite, EX_WB_Write_Data, EX_WB_Write_Reg_Num, Fwd_Sel
  );

  modport slave (
    input  ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_Read_Data,
           ID_EX_Imm_Data, ID_EX_Read_Reg_Num, ID_EX_Write_Reg_Num, Flush,
    output
`ifdef EX_WB_FLAGS_EN
           EX_WB_Zero, EX_WB_Carry,
`endif
           EX_WB_RegWrite, EX_WB_Write_Data, EX_WB_Write_Reg_Num, Fwd_Sel
  );
endinterface

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute stage plus EX/WB pipeline register of the 8-register
// pipelined core. Forwards operand A from the EX/WB register (newest) or the
// WB-hold register (one older), runs a 2-bit ALU and registers the result,
// destination and RegWrite toward the register-file write port.
// Ports:
//   Clk   - rising-edge clock
//   Reset - asynchronous, active-low reset of all state
//   bus   - ex_wb_stage_if.slave: ID/EX fields + Flush in; EX/WB fields and
//           combinational Fwd_Sel (00 none, 01 EX/WB, 10 WB-hold) out
// Optional macro EX_WB_FLAGS_EN: registered Zero/Carry flags.
module ex_wb_stage #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  ex_wb_stage_if.slave  bus
);

  logic              hold_reg_write;
  logic [REG_W-1:0]  hold_reg_num;
  logic [DATA_W-1:0] hold_data;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;
  logic [1:0]        fwd_sel;

  // EX/WB holds the newer value, so it is checked first.
  always_comb begin
    op_a    = bus.ID_EX_Read_Data;
    fwd_sel = 2'b00;
    if (bus.EX_WB_RegWrite && (bus.EX_WB_Write_Reg_Num == bus.ID_EX_Read_Reg_Num)) begin
      op_a    = bus.EX_WB_Write_Data;
      fwd_sel = 2'b01;
    end else if (hold_reg_write && (hold_reg_num == bus.ID_EX_Read_Reg_Num)) begin
      op_a    = hold_data;
      fwd_sel = 2'b10;
    end
  end

  assign bus.Fwd_Sel = fwd_sel;
  assign op_b        = bus.ID_EX_ALUSrc ? bus.ID_EX_Imm_Data : op_a;

  always_comb begin
    result = op_b;
    unique case (bus.ID_EX_ALUOp)
      2'b00:   result = op_b;
      2'b01:   result = op_a + op_b;
      2'b10:   result = op_a - op_b;
      default: result = op_a & op_b;
    endcase
  end

`ifdef EX_WB_FLAGS_EN
  logic carry;

  // Add carries out exactly when the wrapped sum is below an addend.
  always_comb begin
    carry = 1'b0;
    unique case (bus.ID_EX_ALUOp)
      2'b01:   carry = (result < op_a);
      2'b10:   carry = (op_a < op_b);
      default: carry = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bus.EX_WB_Zero  <= 1'b0;
      bus.EX_WB_Carry <= 1'b0;
    end else if (bus.Flush) begin
      bus.EX_WB_Zero  <= 1'b0;
      bus.EX_WB_Carry <= 1'b0;
    end else begin
      bus.EX_WB_Zero  <= (result == '0);
      bus.EX_WB_Carry <= carry;
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bus.EX_WB_RegWrite      <= 1'b0;
      bus.EX_WB_Write_Data    <= '0;
      bus.EX_WB_Write_Reg_Num <= '0;
    end else if (bus.Flush) begin
      bus.EX_WB_RegWrite      <= 1'b0;
      bus.EX_WB_Write_Data    <= '0;
      bus.EX_WB_Write_Reg_Num <= '0;
    end else begin
      bus.EX_WB_RegWrite      <= bus.ID_EX_RegWrite;
      bus.EX_WB_Write_Data    <= result;
      bus.EX_WB_Write_Reg_Num <= bus.ID_EX_Write_Reg_Num;
    end
  end

  // Covers the cycle in which the register file is being written while the
  // consumer's ID-stage read still returned the stale value. Flush does not
  // affect this capture.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hold_reg_write <= 1'b0;
      hold_reg_num   <= '0;
      hold_data      <= '0;
    end else begin
      hold_reg_write <= bus.EX_WB_RegWrite;
      hold_reg_num   <= bus.EX_WB_Write_Reg_Num;
      hold_data      <= bus.EX_WB_Write_Data;
    end
  end

endmodule
